// File: rtl/tdc_therm_encoder.sv
// TDC thermometer encoder: bubble-corrects the chain sample, encodes a fine
// code, pairs it with a coarse count and buffers one timestamp per hit.
module tdc_therm_encoder #(
   parameter int N        = 16,
   parameter int COARSE_W = 16,
   parameter int FINE_W   = 5,
   parameter int DEAD_CYC = 4
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic [N-1:0]               therm,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [COARSE_W+FINE_W-1:0] out_ts,
   output logic [15:0]                drop_cnt,
   output logic                       busy
);

   typedef enum logic {ARMED, DEAD} state_t;
   localparam int DW = $clog2(DEAD_CYC + 1);

   logic [COARSE_W-1:0]        coarse_q;
   logic [N-1:0]               therm_s_q;
   logic [COARSE_W-1:0]        coarse_s_q;
   logic [N-1:0]               cap_c_q;
   logic [COARSE_W-1:0]        cap_coarse_q;
   logic                       cap_v_q;
   state_t                     state_q, state_d;
   logic [DW-1:0]              dead_q, dead_d;
   logic                       out_valid_q, out_valid_d;
   logic [COARSE_W+FINE_W-1:0] out_ts_q, out_ts_d;
   logic [15:0]                drop_q, drop_d;

   logic [N+1:0]               ext;
   logic [N-1:0]               c;
   logic [FINE_W-1:0]          fine;
   logic                       hit;
   logic                       load;

   // Chain sample padded with the implicit first-tap 1 and last-tap 0.
   always_comb begin
      ext = {1'b0, therm_s_q, 1'b1};
      c   = '0;
      for (int i = 0; i < N; i++) begin
         c[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) |
                (ext[i+1] & ext[i+2]);
      end
   end

   always_comb begin
      fine = '0;
      for (int i = 0; i < N; i++) begin
         fine = fine + FINE_W'(cap_c_q[i]);
      end
   end

   always_comb begin
      state_d = state_q;
      dead_d  = dead_q;
      hit     = 1'b0;
      case (state_q)
         ARMED: begin
            if (c[0]) begin
               hit     = 1'b1;
               state_d = DEAD;
               dead_d  = '0;
            end
         end
         DEAD: begin
            if (dead_q < DW'(DEAD_CYC - 1)) begin
               dead_d = dead_q + 1'b1;
            end
            if (dead_q >= DW'(DEAD_CYC - 1) && therm_s_q == '0) begin
               state_d = ARMED;
            end
         end
         default: state_d = ARMED;
      endcase
   end

   always_comb begin
      load        = cap_v_q && (!out_valid_q || out_ready);
      out_valid_d = out_valid_q;
      out_ts_d    = out_ts_q;
      drop_d      = drop_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_ts_d    = {cap_coarse_q, fine};
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (cap_v_q && !load && drop_q != 16'hFFFF) begin
         drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         coarse_q     <= '0;
         therm_s_q    <= '0;
         coarse_s_q   <= '0;
         cap_c_q      <= '0;
         cap_coarse_q <= '0;
         cap_v_q      <= 1'b0;
         state_q      <= ARMED;
         dead_q       <= '0;
         out_valid_q  <= 1'b0;
         out_ts_q     <= '0;
         drop_q       <= '0;
      end else begin
         coarse_q    <= coarse_q + 1'b1;
         therm_s_q   <= therm;
         coarse_s_q  <= coarse_q;
         cap_v_q     <= hit;
         if (hit) begin
            cap_c_q      <= c;
            cap_coarse_q <= coarse_s_q;
         end
         state_q     <= state_d;
         dead_q      <= dead_d;
         out_valid_q <= out_valid_d;
         out_ts_q    <= out_ts_d;
         drop_q      <= drop_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_ts    = out_ts_q;
   assign drop_cnt  = drop_q;
   assign busy      = (state_q != ARMED);

endmodule

// File: tb/tb_tdc_therm_encoder.sv
// Scoreboard bench for tdc_therm_encoder: expected timestamps are queued
// when a hit is driven and compared when the buffer hands them over.
module tb_tdc_therm_encoder;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic [15:0] therm = '0;
   logic        out_ready = 1'b1;
   logic        out_valid;
   logic [20:0] out_ts;
   logic [15:0] drop_cnt;
   logic        busy;

   int total = 0;
   int bad = 0;
   logic [15:0] mcoarse = '0;
   logic [20:0] sb[$];

   tdc_therm_encoder dut (
      .clk(clk), .clr(clr), .therm(therm), .out_ready(out_ready),
      .out_valid(out_valid), .out_ts(out_ts), .drop_cnt(drop_cnt),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mcoarse <= clr ? 16'd0 : mcoarse + 16'd1;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [16:0] model(input logic [15:0] v);
      logic [17:0] e;
      logic [15:0] cc;
      int n;
      e = {1'b0, v, 1'b1};
      for (int i = 0; i < 16; i++) begin
         n = int'(e[i]) + int'(e[i+1]) + int'(e[i+2]);
         cc[i] = (n >= 2);
      end
      return {cc[0], cc};
   endfunction

   // Drives one sample; queues a timestamp when a hit is expected to land.
   task automatic hit(input logic [15:0] v, input bit keep, input int gap);
      logic [16:0] m;
      m = model(v);
      if (keep && m[16])
         sb.push_back({mcoarse, 5'($countones(m[15:0]))});
      therm = v;
      @(posedge clk) #1;
      therm = '0;
      repeat (gap) @(posedge clk) #1;
   endtask

   always @(negedge clk) begin
      if (!clr && out_valid && out_ready) begin
         if (sb.size() == 0) chk("spurious", out_valid, 0);
         else chk("ts", out_ts, sb.pop_front());
      end
   end

   initial begin
      int n;
      repeat (3) @(posedge clk) #1;
      clr = 1'b0;
      chk("rst_valid", out_valid, 0);
      chk("rst_ts", out_ts, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_busy", busy, 0);

      // latency: sample edge, capture edge, then output edge
      hit(16'h00FF, 1, 0);
      @(posedge clk) #1;
      chk("lat_early", out_valid, 0);
      @(posedge clk) #1;
      chk("lat_valid", out_valid, 1);
      repeat (10) @(posedge clk) #1;

      hit(16'h00F7, 1, 12);
      hit(16'h0001, 1, 12);
      hit(16'hFFFF, 1, 12);
      hit(16'h0004, 1, 12);
      chk("nohit_busy", busy, 0);

      // backpressure: first held, second dropped
      out_ready = 1'b0;
      hit(16'h003F, 1, 10);
      chk("bp_valid", out_valid, 1);
      hit(16'h0FFF, 0, 12);
      chk("bp_hold", out_ts, sb[0]);
      chk("bp_drop", drop_cnt, 1);
      out_ready = 1'b1;
      @(posedge clk) #1;
      chk("bp_drained", out_valid, 0);

      // sustained hit: one timestamp, DEAD until chain clears
      sb.push_back({mcoarse, 5'd8});
      therm = 16'h00FF;
      repeat (20) @(posedge clk) #1;
      chk("hold_busy", busy, 1);
      therm = '0;
      @(posedge clk) #1;
      chk("clear_busy1", busy, 1);
      @(posedge clk) #1;
      chk("clear_busy0", busy, 0);
      hit(16'h07FF, 1, 12);

      // coarse wrap
      n = 0;
      while (mcoarse != 16'hFFFF && n < 70000) begin
         @(posedge clk) #1;
         n++;
      end
      hit(16'h001F, 1, 10);
      hit(16'h03FF, 1, 12);

      // clr right after a hit discards it
      hit(16'h00FF, 0, 0);
      clr = 1'b1;
      @(posedge clk) #1;
      clr = 1'b0;
      chk("clr_valid", out_valid, 0);
      chk("clr_drop", drop_cnt, 0);
      chk("clr_busy", busy, 0);
      repeat (6) @(posedge clk) #1;
      chk("clr_quiet", out_valid, 0);

      repeat (5) @(posedge clk) #1;
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
